multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences the lab's multicycle datapath (shared ALU, single unified memory, IR/MDR/A/B/ALUOut registers) over several cycles per instruction. It replaces the single-cycle opcode decoder. Inputs are the IR opcode and a memory-ready handshake; outputs are per-state datapath enables and mux selects.

Parameters:
MEM_WAIT_MAX, 15, max mem_ready_i wait cycles before mem_timeout_o pulses; 0 disables the timeout
OP_W, 6, opcode width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
op_i  in  OP_W  IR[31:26], stable from DECODE until return to FETCH
mem_ready_i  in  1  memory completes the current read/write this cycle
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
iord_o  out  1  memory address select: 0=PC, 1=ALUOut
ir_write_o  out  1  latch IR
pc_write_o  out  1  unconditional PC write
pc_write_cond_o  out  1  PC write if branch condition holds
branch_ne_o  out  1  1: condition is !zero (bne); 0: zero (beq)
pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a_o  out  1  0=PC, 1=A register
alu_src_b_o  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op_o  out  3  000 add, 001 sub, 010 funct-decoded, 011 pass zero-filled imm
reg_dst_o  out  1  0=rt, 1=rd
mem_to_reg_o  out  1  0=ALUOut, 1=MDR
reg_write_o  out  1  register-file write enable
illegal_o  out  1  1-cycle pulse on unknown opcode
mem_timeout_o  out  1  1-cycle pulse on handshake timeout
state_o  out  4  current state encoding
cycle_cnt_o  out  32  see Optional Feature
instr_cnt_o  out  32  see Optional Feature

Behaviour:
- Reset: synchronous, active-low, with one clock domain. Any edge with rst_n=0 sets state to FETCH (0), clears the wait counter, and clears the counters. While rst_n=0, all write/request outputs are forced to 0: mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal, timeout. Selects are 0.
- Opcodes: R 000000, addi 001000, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, LUI_WB 12. Codes 13-15 go to FETCH on the next edge.
- Unlisted outputs in a state are 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready_i=1, and the state then advances to DECODE.
  - Otherwise it holds in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=11, add (branch target to ALUOut).
  - Next state by op: lw/sw->MEM_ADDR; R->R_EXEC; addi->I_EXEC; lui->LUI_WB; beq/bne->BRANCH; j->JUMP.
  - Any other op: illegal_o=1 this cycle, next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; holds until mem_ready_i, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
- MEM_WR: mem_write=1, iord=1; holds until mem_ready_i, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; next R_WB.
- R_WB: reg_write=1, reg_dst=1; next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, add; next I_WB.
- I_WB: reg_write=1, reg_dst=0; next FETCH.
- LUI_WB: alu_op=011, reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01, branch_ne=(op_i==bne); next FETCH.
- JUMP: pc_write=1, pc_source=10; next FETCH.
- Latency with zero wait states (cycles from entering FETCH to returning to FETCH):
  - R 4, addi 4, lw 5, sw 4, beq/bne 3, j 3, lui 3.
  - Each wait cycle adds 1.
- Timeout (applies in FETCH, MEM_RD, MEM_WR):
  - The wait counter increments on each cycle with mem_ready_i=0.
  - It clears on state exit.
  - When it reaches MEM_WAIT_MAX, mem_timeout_o pulses for one cycle and the state goes to FETCH. Any pending write is dropped.
- Simultaneous events:
  - mem_ready_i in the same cycle the timeout is reached: the ready wins and no pulse is generated.
  - rst_n=0 overrides everything.
- Reset mid-instruction: any partial instruction is abandoned and no reg_write/mem_write is issued after the reset edge.

Optional Feature:
PERF_CNT_EN defined:
- cycle_cnt_o increments on every non-reset cycle.
- instr_cnt_o increments on each transition into FETCH from any state other than FETCH. Illegal and timeout exits count as instructions.
- Both are 32-bit and wrap from 0xFFFFFFFF to 0.

Not defined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- addi fetched with mem_ready_i tied 1 -> state_o 0,1,10,11,0. reg_write=1 only in state 11 with reg_dst=0. Total 4 cycles.
- lw with mem_ready_i low 2 cycles in MEM_RD -> state_o 0,1,2,3,3,3,4,0. mem_read/iord=1 for 3 cycles, then reg_write with mem_to_reg=1.
- bne -> states 0,1,8. pc_write_cond=1, branch_ne=1, pc_source=01, alu_op=001 in state 8.
- op_i=111111 in DECODE -> illegal_o pulses exactly 1 cycle; next state 0; no reg_write or mem_write at any point.
- rst_n=0 for 1 edge during MEM_WR -> state_o=0 next cycle, mem_write=0.
- With MEM_WAIT_MAX=3, mem_ready_i held 0 in MEM_WR -> timeout pulse, then FETCH.
- PERF_CNT_EN defined; run R, j, lw back-to-back with no waits -> instr_cnt_o=3, cycle_cnt_o=12.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle controller: opcode and memory
// handshake in, datapath enables/selects and status out.
interface multicycle_ctrl_if #(
    parameter int unsigned OP_W = 6
);
    logic [OP_W-1:0] op_i;
    logic            mem_ready_i;
    logic            mem_read_o;
    logic            mem_write_o;
    logic            iord_o;
    logic            ir_write_o;
    logic            pc_write_o;
    logic            pc_write_cond_o;
    logic            branch_ne_o;
    logic [1:0]      pc_source_o;
    logic            alu_src_a_o;
    logic [1:0]      alu_src_b_o;
    logic [2:0]      alu_op_o;
    logic            reg_dst_o;
    logic            mem_to_reg_o;
    logic            reg_write_o;
    logic            illegal_o;
    logic            mem_timeout_o;
    logic [3:0]      state_o;
    logic [31:0]     cycle_cnt_o;
    logic [31:0]     instr_cnt_o;

    modport master (
        input  op_i, mem_ready_i,
        output mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
               pc_write_cond_o, branch_ne_o, pc_source_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o,
               illegal_o, mem_timeout_o, state_o, cycle_cnt_o, instr_cnt_o
    );

    modport slave (
        output op_i, mem_ready_i,
        input  mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
               pc_write_cond_o, branch_ne_o, pc_source_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o,
               illegal_o, mem_timeout_o, state_o, cycle_cnt_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the multicycle datapath, with memory-wait timeout.
// Optional performance counters are built when PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned OP_W         = 6
) (
    input  logic                clk_i,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        LUI_WB   = 4'd12
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                waiting_c;
    logic                timeout_c;

    // Handshake states; the timeout fires on the MEM_WAIT_MAX-th idle cycle unless ready arrives.
    assign waiting_c = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout_c = (MEM_WAIT_MAX != 0) && waiting_c && !bus.mem_ready_i &&
                       (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state; the wait counter only survives while holding in a handshake state.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready_i)  state_d = DECODE;
                else if (!timeout_c)  wait_d  = wait_q + WAIT_W'(1);
            end
            DECODE: begin
                case (bus.op_i)
                    OP_LW, OP_SW:   state_d = MEM_ADDR;
                    OP_R:           state_d = R_EXEC;
                    OP_ADDI:        state_d = I_EXEC;
                    OP_LUI:         state_d = LUI_WB;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    default:        state_d = FETCH;
                endcase
            end
            MEM_ADDR: state_d = (bus.op_i == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (bus.mem_ready_i)  state_d = MEM_WB;
                else if (timeout_c)   state_d = FETCH;
                else                  wait_d  = wait_q + WAIT_W'(1);
            end
            MEM_WR: begin
                if (bus.mem_ready_i || timeout_c) state_d = FETCH;
                else                              wait_d  = wait_q + WAIT_W'(1);
            end
            R_EXEC:  state_d = R_WB;
            I_EXEC:  state_d = I_WB;
            default: state_d = FETCH;
        endcase
    end

    // Per-state datapath controls; everything is held low while reset is asserted.
    always_comb begin
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.iord_o          = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.pc_write_o      = 1'b0;
        bus.pc_write_cond_o = 1'b0;
        bus.branch_ne_o     = 1'b0;
        bus.pc_source_o     = 2'b00;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = 2'b00;
        bus.alu_op_o        = 3'b000;
        bus.reg_dst_o       = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.reg_write_o     = 1'b0;
        bus.illegal_o       = 1'b0;
        bus.mem_timeout_o   = 1'b0;
        if (rst_n) begin
            bus.mem_timeout_o = timeout_c;
            case (state_q)
                FETCH: begin
                    bus.mem_read_o  = 1'b1;
                    bus.alu_src_b_o = 2'b01;
                    bus.ir_write_o  = bus.mem_ready_i;
                    bus.pc_write_o  = bus.mem_ready_i;
                end
                DECODE: begin
                    bus.alu_src_b_o = 2'b11;
                    case (bus.op_i)
                        OP_R, OP_ADDI, OP_LUI, OP_LW, OP_SW,
                        OP_BEQ, OP_BNE, OP_J: bus.illegal_o = 1'b0;
                        default:              bus.illegal_o = 1'b1;
                    endcase
                end
                MEM_ADDR: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_src_b_o = 2'b10;
                end
                MEM_RD: begin
                    bus.mem_read_o = 1'b1;
                    bus.iord_o     = 1'b1;
                end
                MEM_WB: begin
                    bus.reg_write_o  = 1'b1;
                    bus.mem_to_reg_o = 1'b1;
                end
                MEM_WR: begin
                    bus.mem_write_o = 1'b1;
                    bus.iord_o      = 1'b1;
                end
                R_EXEC: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_op_o    = 3'b010;
                end
                R_WB: begin
                    bus.reg_write_o = 1'b1;
                    bus.reg_dst_o   = 1'b1;
                end
                I_EXEC: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_src_b_o = 2'b10;
                end
                I_WB:   bus.reg_write_o = 1'b1;
                LUI_WB: begin
                    bus.alu_op_o    = 3'b011;
                    bus.reg_write_o = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a_o     = 1'b1;
                    bus.alu_op_o        = 3'b001;
                    bus.pc_write_cond_o = 1'b1;
                    bus.pc_source_o     = 2'b01;
                    bus.branch_ne_o     = (bus.op_i == OP_BNE);
                end
                JUMP: begin
                    bus.pc_write_o  = 1'b1;
                    bus.pc_source_o = 2'b10;
                end
                default: bus.mem_read_o = 1'b0;
            endcase
        end
    end

    assign bus.state_o = state_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;

    // Every exit back to FETCH retires one instruction, including illegal/timeout exits.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (state_d == FETCH && state_q != FETCH) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign bus.cycle_cnt_o = cycle_cnt_q;
    assign bus.instr_cnt_o = instr_cnt_q;
`else
    assign bus.cycle_cnt_o = 32'd0;
    assign bus.instr_cnt_o = 32'd0;
`endif
endmodule
